// File: rtl/aurora_ctrl_decoder.sv
// aurora_ctrl_decoder: VIO control bus receiver - sync/glitch filter, request edge decode, GT/core reset sequencer.
// Latency: aurora_ctrl -> loopback/tx_en 2+STABLE_CYCLES cycles, -> FSM reaction and err_clr one cycle more.
// No backpressure: static levels in, static levels out. AURORA_CTRL_AUTO_RETRY_EN enables automatic timeout retries.
module aurora_ctrl_decoder #(
  parameter int STABLE_CYCLES   = 4,
  parameter int GT_RST_CYCLES   = 64,
  parameter int CORE_RST_CYCLES = 32,
  parameter int UP_TIMEOUT      = 65536,
  parameter int MAX_RETRY       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] aurora_ctrl,
  input  logic       channel_up,
  output logic       gt_reset,
  output logic       aurora_reset,
  output logic [2:0] loopback,
  output logic       tx_en,
  output logic       err_clr,
  output logic       seq_busy,
  output logic       link_fail,
  output logic [7:0] aurora_status
);

  localparam int FW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int MAX_A   = (GT_RST_CYCLES > CORE_RST_CYCLES) ? GT_RST_CYCLES : CORE_RST_CYCLES;
  localparam int MAX_CYC = (MAX_A > UP_TIMEOUT) ? MAX_A : UP_TIMEOUT;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GT_RST   = 3'd1,
    ST_CORE_RST = 3'd2,
    ST_WAIT_UP  = 3'd3,
    ST_FAIL     = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    retry_cnt;
  logic          link_lost;
  logic          up_d;

  logic [6:0]    sync1;
  logic [6:0]    sync2;
  logic [6:0]    filt;
  logic [FW-1:0] fcnt [7];
  logic [2:0]    req_d;
  logic          soft_rise;
  logic          gt_rise;
  logic          clr_rise;

  logic unused_reserved;
  assign unused_reserved = aurora_ctrl[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= aurora_ctrl[6:0];
      sync2 <= sync1;
    end
  end

  // A bit is accepted only after STABLE_CYCLES consecutive samples disagreeing with the current value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int i = 0; i < 7; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(STABLE_CYCLES - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign loopback  = filt[4:2];
  assign tx_en     = filt[5];
  assign soft_rise = filt[0] & ~req_d[0];
  assign gt_rise   = filt[1] & ~req_d[1];
  assign clr_rise  = filt[6] & ~req_d[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d     <= '0;
      err_clr   <= 1'b0;
      up_d      <= 1'b0;
      link_lost <= 1'b0;
    end else begin
      req_d   <= {filt[6], filt[1], filt[0]};
      err_clr <= clr_rise;
      up_d    <= channel_up;
      if (state == ST_IDLE && up_d && !channel_up) link_lost <= 1'b1;
      else if (err_clr)                            link_lost <= 1'b0;
    end
  end

`ifndef AURORA_CTRL_AUTO_RETRY_EN
  logic unused_retry_cfg;
  assign unused_retry_cfg = (MAX_RETRY > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_GT_RST;
      cnt          <= '0;
      retry_cnt    <= '0;
      gt_reset     <= 1'b1;
      aurora_reset <= 1'b1;
      seq_busy     <= 1'b1;
      link_fail    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (err_clr) link_fail <= 1'b0;
          if (gt_rise) begin
            state        <= ST_GT_RST;
            cnt          <= '0;
            gt_reset     <= 1'b1;
            aurora_reset <= 1'b1;
            seq_busy     <= 1'b1;
          end else if (soft_rise) begin
            state        <= ST_CORE_RST;
            cnt          <= '0;
            aurora_reset <= 1'b1;
            seq_busy     <= 1'b1;
          end
        end
        ST_GT_RST: begin
          if (gt_rise) begin
            cnt <= '0;
          end else if (cnt == CW'(GT_RST_CYCLES - 1)) begin
            state    <= ST_CORE_RST;
            cnt      <= '0;
            gt_reset <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_CORE_RST: begin
          if (gt_rise) begin
            state    <= ST_GT_RST;
            cnt      <= '0;
            gt_reset <= 1'b1;
          end else if (cnt == CW'(CORE_RST_CYCLES - 1)) begin
            state        <= ST_WAIT_UP;
            cnt          <= '0;
            aurora_reset <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT_UP: begin
          if (gt_rise) begin
            state        <= ST_GT_RST;
            cnt          <= '0;
            gt_reset     <= 1'b1;
            aurora_reset <= 1'b1;
          end else if (channel_up) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            retry_cnt <= '0;
            seq_busy  <= 1'b0;
          end else if (cnt == CW'(UP_TIMEOUT - 1)) begin
`ifdef AURORA_CTRL_AUTO_RETRY_EN
            if (int'(retry_cnt) < MAX_RETRY) begin
              if (retry_cnt != 2'd3) retry_cnt <= retry_cnt + 2'd1;
              state        <= ST_GT_RST;
              cnt          <= '0;
              gt_reset     <= 1'b1;
              aurora_reset <= 1'b1;
            end else begin
              state     <= ST_FAIL;
              cnt       <= '0;
              seq_busy  <= 1'b0;
              link_fail <= 1'b1;
            end
`else
            state     <= ST_FAIL;
            cnt       <= '0;
            seq_busy  <= 1'b0;
            link_fail <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_FAIL: begin
          if (gt_rise) begin
            state        <= ST_GT_RST;
            cnt          <= '0;
            retry_cnt    <= '0;
            gt_reset     <= 1'b1;
            aurora_reset <= 1'b1;
            seq_busy     <= 1'b1;
            link_fail    <= 1'b0;
          end else if (soft_rise) begin
            state        <= ST_CORE_RST;
            cnt          <= '0;
            retry_cnt    <= '0;
            aurora_reset <= 1'b1;
            seq_busy     <= 1'b1;
            link_fail    <= 1'b0;
          end
        end
        default: begin
          state        <= ST_GT_RST;
          cnt          <= '0;
          gt_reset     <= 1'b1;
          aurora_reset <= 1'b1;
          seq_busy     <= 1'b1;
        end
      endcase
    end
  end

  assign aurora_status = {state, retry_cnt, link_lost, link_fail, channel_up};

endmodule

// File: tb/tb_aurora_ctrl_decoder.sv
// Testbench for aurora_ctrl_decoder: randomized request timing checked against timing rules computed per cycle.
`timescale 1ns/1ps
module tb_aurora_ctrl_decoder;

  localparam int STB   = 4;
  localparam int GTC   = 8;
  localparam int COREC = 4;
  localparam int UPT   = 32;
  localparam int MAXR  = 2;
  localparam int LAT   = 2 + STB;        // input change -> filtered output
  localparam int REQ   = LAT + 1;        // input change -> FSM state change
  localparam int SEQ   = GTC + COREC + UPT;
`ifdef AURORA_CTRL_AUTO_RETRY_EN
  localparam int NSEQ  = MAXR + 1;
`else
  localparam int NSEQ  = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] aurora_ctrl = 8'h00;
  logic       channel_up = 1'b0;
  logic       gt_reset, aurora_reset, tx_en, err_clr, seq_busy, link_fail;
  logic [2:0] loopback;
  logic [7:0] aurora_status;

  int vec  = 0;
  int errs = 0;
  logic [2:0] lb_old = 3'd0;

  always #5 clk = ~clk;

  aurora_ctrl_decoder #(
    .STABLE_CYCLES(STB), .GT_RST_CYCLES(GTC), .CORE_RST_CYCLES(COREC),
    .UP_TIMEOUT(UPT), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .aurora_ctrl(aurora_ctrl), .channel_up(channel_up),
    .gt_reset(gt_reset), .aurora_reset(aurora_reset), .loopback(loopback), .tx_en(tx_en),
    .err_clr(err_clr), .seq_busy(seq_busy), .link_fail(link_fail), .aurora_status(aurora_status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // State/retry t cycles after GT_RST is entered, with channel_up held low throughout.
  function automatic void seq_model(input int t, output int st, output int rc);
    if (t >= NSEQ * SEQ) begin
      st = 4;
      rc = NSEQ - 1;
    end else begin
      rc = t / SEQ;
      st = (t % SEQ < GTC) ? 1 : (t % SEQ < GTC + COREC) ? 2 : 3;
    end
  endfunction

  // {gt_reset, aurora_reset, seq_busy} demanded in each state.
  function automatic logic [2:0] drive_of(input int st);
    case (st)
      1:       return 3'b111;
      2:       return 3'b011;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; aurora_ctrl = 8'h00; channel_up = 1'b0;
    repeat (3) tick();
    vec++;
    if ({gt_reset, aurora_reset, seq_busy, link_fail, err_clr, tx_en} !== 6'b111000) begin
      errs++;
      $display("FAIL reset_ctl: got %b want 111000", {gt_reset, aurora_reset, seq_busy, link_fail, err_clr, tx_en});
    end
    vec++;
    if (loopback !== 3'd0) begin
      errs++; $display("FAIL reset_loopback: got %b want 000", loopback);
    end
    vec++;
    if (aurora_status !== 8'b001_00_0_0_0) begin
      errs++; $display("FAIL reset_status: got %b want 00100000", aurora_status);
    end
  endtask

  task automatic test_power_on();
    int gt_hi = 0;
    int ar_hi = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 20) channel_up = 1'b1;
      if (gt_reset)     gt_hi++;
      if (aurora_reset) ar_hi++;
      tick();
    end
    vec++;
    if (gt_hi != GTC) begin
      errs++; $display("FAIL pwr_gt_len: got %0d want %0d", gt_hi, GTC);
    end
    vec++;
    if (ar_hi != GTC + COREC) begin
      errs++; $display("FAIL pwr_ar_len: got %0d want %0d", ar_hi, GTC + COREC);
    end
    vec++;
    if ({aurora_status[7:5], seq_busy, link_fail, aurora_status[0]} !== 6'b000001) begin
      errs++;
      $display("FAIL pwr_idle: got %b want 000001", {aurora_status[7:5], seq_busy, link_fail, aurora_status[0]});
    end
  endtask

  task automatic test_soft_reset();
    int hold = $urandom_range(12, 4);
    int st;
    for (int o = 0; o < 20; o++) begin
      if (o == 0)    aurora_ctrl[0] = 1'b1;
      if (o == hold) aurora_ctrl[0] = 1'b0;
      st = (o >= REQ && o < REQ + COREC) ? 2 : (o == REQ + COREC) ? 3 : 0;
      vec++;
      if ({gt_reset, aurora_reset, seq_busy, aurora_status[7:5]} !== {drive_of(st), 3'(st)}) begin
        errs++;
        $display("FAIL soft_rst o=%0d: got %b want %b", o,
                 {gt_reset, aurora_reset, seq_busy, aurora_status[7:5]}, {drive_of(st), 3'(st)});
      end
      tick();
    end
  endtask

  task automatic test_filter();
    int lens [6];
    logic exp_tx;
    logic [2:0] v;
    lens = '{3, 6, 0, 0, 0, 0};
    for (int k = 2; k < 6; k++) lens[k] = $urandom_range(8, 1);
    foreach (lens[k]) begin
      for (int o = 0; o < lens[k] + 10; o++) begin
        if (o == 0)       aurora_ctrl[5] = 1'b1;
        if (o == lens[k]) aurora_ctrl[5] = 1'b0;
        exp_tx = (lens[k] >= STB) && (o >= LAT) && (o < lens[k] + LAT);
        vec++;
        if (tx_en !== exp_tx) begin
          errs++; $display("FAIL tx_en len=%0d o=%0d: got %b want %b", lens[k], o, tx_en, exp_tx);
        end
        tick();
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 0) v = 3'b010;
      else begin
        v = 3'($urandom_range(7, 1));
        while (v == lb_old) v = 3'($urandom_range(7, 1));
      end
      for (int o = 0; o < 10; o++) begin
        if (o == 0) aurora_ctrl[4:2] = v;
        vec++;
        if (loopback !== ((o < LAT) ? lb_old : v)) begin
          errs++;
          $display("FAIL loopback o=%0d: got %b want %b", o, loopback, (o < LAT) ? lb_old : v);
        end
        tick();
      end
      lb_old = v;
    end
  endtask

  task automatic test_both_edges();
    int st, rc;
    for (int o = 0; o < 26; o++) begin
      if (o == 0) aurora_ctrl[1:0] = 2'b11;
      if (o == 8) aurora_ctrl[1:0] = 2'b00;
      if (o >= REQ && o - REQ <= GTC + COREC) seq_model(o - REQ, st, rc);
      else st = 0;
      vec++;
      if ({gt_reset, aurora_reset, seq_busy, aurora_status[7:5]} !== {drive_of(st), 3'(st)}) begin
        errs++;
        $display("FAIL both_req o=%0d: got %b want %b", o,
                 {gt_reset, aurora_reset, seq_busy, aurora_status[7:5]}, {drive_of(st), 3'(st)});
      end
      tick();
    end
  endtask

  task automatic test_link_lost();
    for (int o = 0; o < 4; o++) begin
      if (o == 0) channel_up = 1'b0;
      vec++;
      if (aurora_status[2] !== (o >= 1)) begin
        errs++; $display("FAIL link_lost_set o=%0d: got %b want %b", o, aurora_status[2], o >= 1);
      end
      tick();
    end
    for (int o = 0; o < 16; o++) begin
      if (o == 0) aurora_ctrl[6] = 1'b1;
      if (o == 8) aurora_ctrl[6] = 1'b0;
      vec++;
      if ({err_clr, aurora_status[2]} !== {o == REQ, o <= REQ}) begin
        errs++;
        $display("FAIL err_clr o=%0d: got %b want %b", o, {err_clr, aurora_status[2]}, {o == REQ, o <= REQ});
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    localparam int RESTART = 20 + REQ;
    int st, rc;
    channel_up = 1'b0;
    for (int o = 0; o < RESTART + NSEQ * SEQ + 6; o++) begin
      if (o == 0)  aurora_ctrl[1] = 1'b1;
      if (o == 6)  aurora_ctrl[1] = 1'b0;
      if (o == 10) aurora_ctrl[0] = 1'b1;
      if (o == 20) aurora_ctrl[1] = 1'b1;
      if (o < REQ) begin
        st = 0; rc = 0;
      end else seq_model(o - ((o < RESTART) ? REQ : RESTART), st, rc);
      vec++;
      if (aurora_status[7:3] !== {3'(st), 2'(rc)}) begin
        errs++;
        $display("FAIL tmo_status o=%0d: got %b want %b", o, aurora_status[7:3], {3'(st), 2'(rc)});
      end
      vec++;
      if ({gt_reset, aurora_reset, seq_busy, link_fail} !== {drive_of(st), st == 4}) begin
        errs++;
        $display("FAIL tmo_ctl o=%0d: got %b want %b", o,
                 {gt_reset, aurora_reset, seq_busy, link_fail}, {drive_of(st), st == 4});
      end
      tick();
    end
  endtask

  task automatic test_fail_recover();
    int st, rc;
    for (int o = 0; o < 10; o++) begin
      if (o == 0) aurora_ctrl[1:0] = 2'b00;
      vec++;
      if ({aurora_status[7:5], link_fail} !== 4'b1001) begin
        errs++; $display("FAIL fail_hold o=%0d: got %b want 1001", o, {aurora_status[7:5], link_fail});
      end
      tick();
    end
    for (int o = 0; o < 18; o++) begin
      if (o == 0) begin
        channel_up = 1'b1;
        aurora_ctrl[0] = 1'b1;
      end
      if (o == 10) aurora_ctrl[0] = 1'b0;
      st = (o < REQ) ? 4 : (o - REQ < COREC) ? 2 : (o - REQ == COREC) ? 3 : 0;
      rc = (o < REQ) ? NSEQ - 1 : 0;
      vec++;
      if ({aurora_status[7:3], link_fail} !== {3'(st), 2'(rc), o < REQ}) begin
        errs++;
        $display("FAIL fail_exit o=%0d: got %b want %b", o, {aurora_status[7:3], link_fail}, {3'(st), 2'(rc), o < REQ});
      end
      vec++;
      if ({gt_reset, aurora_reset, seq_busy} !== drive_of(st)) begin
        errs++;
        $display("FAIL fail_exit_ctl o=%0d: got %b want %b", o, {gt_reset, aurora_reset, seq_busy}, drive_of(st));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int o = 0; o < 15; o++) begin
      if (o == 0) begin
        channel_up = 1'b0;
        aurora_ctrl[0] = 1'b1;
      end
      tick();
    end
    vec++;
    if (aurora_status[7:5] !== 3'd3) begin
      errs++; $display("FAIL mid_pre_state: got %0d want 3", aurora_status[7:5]);
    end
    rst_n = 1'b0;
    aurora_ctrl = 8'h00;
    #1;
    vec++;
    if ({gt_reset, aurora_reset, seq_busy, link_fail, err_clr, tx_en, loopback} !== 9'b111000_000) begin
      errs++;
      $display("FAIL mid_reset_ctl: got %b want 111000000",
               {gt_reset, aurora_reset, seq_busy, link_fail, err_clr, tx_en, loopback});
    end
    vec++;
    if (aurora_status !== 8'b001_00_0_0_0) begin
      errs++; $display("FAIL mid_reset_status: got %b want 00100000", aurora_status);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    channel_up = 1'b1;
    for (int o = 0; o < 10; o++) begin
      vec++;
      if (gt_reset !== (o < GTC)) begin
        errs++; $display("FAIL mid_restart o=%0d: got %b want %b", o, gt_reset, o < GTC);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft_reset();
    test_soft_reset();
    test_filter();
    test_both_edges();
    test_link_lost();
    test_timeout();
    test_fail_recover();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
